// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi front-end sequencer.
// Code-rate encodings, controller states and slices-per-word.
package viterbi_pkg;

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  localparam int SLICES_PER_WORD_R2 = 4;
  localparam int SLICES_PER_WORD_R3 = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SLICE,
    DRAIN,
    TB_WAIT,
    DONE
  } slice_ctrl_state_t;

  // Index of the final slice within one word for a given rate.
  function automatic logic [1:0] last_slice(input logic rate);
    if (rate == CODE_RATE_3)
      return 2'(SLICES_PER_WORD_R3 - 1);
    return 2'(SLICES_PER_WORD_R2 - 1);
  endfunction

endpackage

// File: rtl/slice_ctrl_if.sv
// Received-word stream between the PS-side source and the controller.
// Plain valid/ready handshake carrying one 16-bit frame word.
interface slice_ctrl_if;
  logic [15:0] i_word;
  logic        i_word_valid;
  logic        o_word_ready;

  modport master (
    output i_word,
    output i_word_valid,
    input  o_word_ready
  );

  modport slave (
    input  i_word,
    input  i_word_valid,
    output o_word_ready
  );
endinterface

// File: rtl/slice_ctrl_en_pipe.sv
// Enable shift register feeding branch-metric and ACS stages.
// Bit 0 is the slicer enable delayed one cycle; bit DEPTH-1 the oldest.
module en_pipe #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [DEPTH-1:0] q_o
);

  logic [DEPTH-1:0] sh_q;

  // Shift the slicer enable down the line; clear drops any wave in flight.
  always_ff @(posedge clk) begin
    if (clr_i)
      sh_q <= '0;
    else
      sh_q <= {sh_q[DEPTH-2:0], en_i};
  end

  assign q_o = sh_q;

endmodule

// File: rtl/slice_ctrl.sv
// Viterbi front-end sequencer: word fetch, slice enables, enable wave,
// traceback window requests and end-of-data signalling.
module slice_ctrl
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 12,
  parameter int BM_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_code_rate,
  input  logic [15:0]        i_num_words,
  slice_ctrl_if.slave        word_if,
  input  logic               i_tb_done,
  output logic [15:0]        o_data_frame,
  output logic               o_code_rate,
  output logic               o_en_s,
  output logic               o_en_bm,
  output logic               o_en_acs,
  output logic               o_tb_start,
  output logic               o_ood,
  output logic               o_busy,
  output logic               o_done
);

  localparam int SW = $clog2(TB_DEPTH + 1);
  localparam int PD = 1 + BM_LAT;

  slice_ctrl_state_t state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   rem_q, rem_d;
  logic          rate_q, rate_d;
  logic [15:0]   frame_q, frame_d;
  logic [SW-1:0] step_q, step_d;
  logic [1:0]    out_q, out_d;

  logic          ready;
  logic          en_s;
  logic          drain_fire;
  logic          acs_wrap;
  logic [PD-1:0] pipe_q;
  logic          pipe_empty;

  en_pipe #(.DEPTH(PD)) u_pipe (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (en_s),
    .q_o   (pipe_q)
  );

  assign pipe_empty = ~|pipe_q;
  assign o_en_bm    = pipe_q[0];
  assign o_en_acs   = pipe_q[BM_LAT];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      rate_q  <= 1'b0;
      frame_q <= '0;
      step_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      rate_q  <= rate_d;
      frame_q <= frame_d;
      step_q  <= step_d;
      out_q   <= out_d;
    end
  end

  // Frame sequencing: fetch words, slice them, drain, wait for traceback.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    rate_d     = rate_q;
    frame_d    = frame_q;
    ready      = 1'b0;
    en_s       = 1'b0;
    drain_fire = 1'b0;
    o_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_num_words == '0) begin
            state_d = DONE;
          end else begin
            rate_d  = i_code_rate;
            rem_d   = i_num_words;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        ready = 1'b1;
        if (word_if.i_word_valid) begin
          frame_d = word_if.i_word;
          cnt_d   = '0;
          rem_d   = rem_q - 16'd1;
          state_d = SLICE;
        end
      end
      SLICE: begin
        en_s = 1'b1;
        if (cnt_q != last_slice(rate_q)) begin
          cnt_d = cnt_q + 2'd1;
        end else if (rem_q != '0) begin
          ready = 1'b1;
          if (word_if.i_word_valid) begin
            frame_d = word_if.i_word;
            cnt_d   = '0;
            rem_d   = rem_q - 16'd1;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          drain_fire = 1'b1;
          state_d    = TB_WAIT;
        end
      end
      TB_WAIT: begin
        if (out_q == '0)
          state_d = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ACS step counting; a full window fires with its last ACS step.
  always_comb begin
    acs_wrap = o_en_acs && (step_q == SW'(TB_DEPTH - 1));
    step_d   = step_q;
    if (o_en_acs)
      step_d = acs_wrap ? '0 : step_q + SW'(1);
    if (drain_fire)
      step_d = '0;
  end

  assign o_tb_start = acs_wrap | (drain_fire & (step_q != '0));
  assign o_ood      = drain_fire;

  // Outstanding traceback requests, saturating at 3.
  always_comb begin
    out_d = out_q;
    case ({o_tb_start, i_tb_done})
      2'b10:   if (out_q != 2'd3) out_d = out_q + 2'd1;
      2'b01:   if (out_q != 2'd0) out_d = out_q - 2'd1;
      default: out_d = out_q;
    endcase
  end

  assign word_if.o_word_ready = ready;
  assign o_en_s       = en_s;
  assign o_data_frame = frame_q;
  assign o_code_rate  = rate_q;
  assign o_busy       = (state_q != IDLE);

  // A fourth request with three already pending is a protocol error.
  a_tb_ovf: assert property (@(posedge clk) disable iff (rst)
    !(o_tb_start && !i_tb_done && out_q == 2'd3));

endmodule

// File: tb/tb_slice_ctrl.sv
// Self-checking bench for slice_ctrl against a cycle-schedule model.
// Model derives acceptance, enable and traceback timing from frame rules.
module tb_slice_ctrl;
  import viterbi_pkg::*;

  localparam int TB_DEPTH = 12;
  localparam int BM_LAT   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_code_rate = 1'b0;
  logic [15:0] i_num_words = '0;
  logic        i_tb_done = 1'b0;
  logic [15:0] o_data_frame;
  logic        o_code_rate, o_en_s, o_en_bm, o_en_acs;
  logic        o_tb_start, o_ood, o_busy, o_done;

  slice_ctrl_if wif();

  slice_ctrl #(.TB_DEPTH(TB_DEPTH), .BM_LAT(BM_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_code_rate  (i_code_rate),
    .i_num_words  (i_num_words),
    .word_if      (wif),
    .i_tb_done    (i_tb_done),
    .o_data_frame (o_data_frame),
    .o_code_rate  (o_code_rate),
    .o_en_s       (o_en_s),
    .o_en_bm      (o_en_bm),
    .o_en_acs     (o_en_acs),
    .o_tb_start   (o_tb_start),
    .o_ood        (o_ood),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {en_s, en_bm, en_acs, tb_start, ood, word_ready, busy, done}
  function automatic logic [7:0] ctl_obs();
    return {o_en_s, o_en_bm, o_en_acs, o_tb_start, o_ood,
            wif.o_word_ready, o_busy, o_done};
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // avail[k]: first cycle the source can offer word k (held once raised).
  // coincide: answer request 0 exactly when request 1 is issued.
  task automatic run_frame(input logic rate, input int n,
                           input int avail[$], input bit coincide,
                           input int abort_at);
    int spw, tot, last_s, dd, td, tend, cnt, sent, a, d, t;
    int acc[$];
    int tbs[$];
    int tdn[$];
    logic [15:0] words[$];
    bit e_s[];
    int e_w[];
    bit live, es0, es1, es2, rdy, tb, dn;
    logic [7:0] ev;

    spw = (rate == CODE_RATE_3) ? SLICES_PER_WORD_R3 : SLICES_PER_WORD_R2;
    for (int i = 0; i < n; i++) begin
      words.push_back(16'($urandom));
      a = (i < avail.size()) ? avail[i] : 0;
      if (i == 0) acc.push_back(imax(1, a));
      else        acc.push_back(imax(acc[i-1] + spw, a));
    end
    tot    = n * spw;
    last_s = (n > 0) ? acc[n-1] + spw : 0;
    dd     = last_s + 2 + BM_LAT;
    e_s    = new[dd + 4];
    e_w    = new[dd + 4];
    for (int k = 0; k < n; k++)
      for (int j = 1; j <= spw; j++) begin
        e_s[acc[k] + j] = 1'b1;
        e_w[acc[k] + j] = k;
      end
    cnt = 0;
    if (n > 0) begin
      for (int c = 1 + BM_LAT; c < dd; c++)
        if (e_s[c - 1 - BM_LAT]) begin
          cnt++;
          if (cnt % TB_DEPTH == 0) tbs.push_back(c);
        end
      if (tot % TB_DEPTH != 0) tbs.push_back(dd);
    end
    for (int i = 0; i < tbs.size(); i++) begin
      d = $urandom_range(1, 8);
      if (coincide && i == 0 && tbs.size() > 1) d = tbs[1] - tbs[0];
      if (coincide && i == 1) d = 10;
      t = tbs[i] + d;
      if (i > 0 && t <= tdn[i-1]) t = tdn[i-1] + 1;
      tdn.push_back(t);
    end
    if (n == 0)             td = 1;
    else if (tdn.size() > 0) td = imax(dd, tdn[tdn.size()-1]) + 2;
    else                    td = dd + 2;
    tend = (abort_at >= 0) ? abort_at + 3 : td + 2;

    i_code_rate = rate;
    i_num_words = 16'(n);
    sent = 0;
    for (int c = 0; c < tend; c++) begin
      @(posedge clk);
      #1;
      live    = (abort_at < 0) || (c <= abort_at);
      i_start = (c == 0);
      rst     = (c == abort_at);
      a = (sent < avail.size()) ? avail[sent] : 0;
      wif.i_word_valid = live && (sent < n) && (c >= a);
      wif.i_word       = (sent < n) ? words[sent] : 16'h0;
      tb = 1'b0;
      foreach (tdn[i]) if (tdn[i] == c) tb = 1'b1;
      i_tb_done = live && tb;
      @(negedge clk);
      if (wif.i_word_valid && wif.o_word_ready) sent++;
      if (!live) begin
        chk($sformatf("abort_ctl@%0d", c), 32'(ctl_obs()), 32'd0);
        chk($sformatf("abort_frame@%0d", c), 32'(o_data_frame), 32'd0);
        chk($sformatf("abort_rate@%0d", c), 32'(o_code_rate), 32'd0);
      end else begin
        es0 = (c < e_s.size()) && e_s[c];
        es1 = (c >= 1) && (c - 1 < e_s.size()) && e_s[c-1];
        es2 = (c >= 1 + BM_LAT) && (c - 1 - BM_LAT < e_s.size())
              && e_s[c-1-BM_LAT];
        rdy = 1'b0;
        for (int k = 0; k < n; k++)
          if (c >= ((k == 0) ? 1 : acc[k-1] + spw) && c <= acc[k])
            rdy = 1'b1;
        tb = 1'b0;
        foreach (tbs[i]) if (tbs[i] == c) tb = 1'b1;
        dn = (c == td);
        ev = {es0, es1, es2, tb, (n > 0) && (c == dd), rdy,
              (c >= 1) && (c <= td), dn};
        chk($sformatf("ctl r%0d n%0d @%0d", rate, n, c),
            32'(ctl_obs()), 32'(ev));
        if (es0)
          chk($sformatf("frame @%0d", c), 32'(o_data_frame),
              32'(words[e_w[c]]));
        if (c == 1 && n > 0)
          chk("code_rate", 32'(o_code_rate), 32'(rate));
      end
    end
    i_start = 1'b0;
    rst = 1'b0;
    wif.i_word_valid = 1'b0;
    i_tb_done = 1'b0;
  endtask

  initial begin
    int av[$];
    int nn;
    logic rr;
    wif.i_word = '0;
    wif.i_word_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 32'(ctl_obs()), 32'd0);
    chk("reset_frame", 32'(o_data_frame), 32'd0);
    chk("reset_rate", 32'(o_code_rate), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    av = {};
    run_frame(CODE_RATE_2, 3, av, 1'b0, -1);
    run_frame(CODE_RATE_3, 5, av, 1'b0, -1);
    av = {0, 8, 0};
    run_frame(CODE_RATE_2, 3, av, 1'b0, -1);
    av = {};
    run_frame(CODE_RATE_2, 0, av, 1'b0, -1);
    run_frame(CODE_RATE_2, 3, av, 1'b0, 4);
    run_frame(CODE_RATE_2, 4, av, 1'b0, -1);
    run_frame(CODE_RATE_2, 6, av, 1'b1, -1);
    run_frame(CODE_RATE_3, 12, av, 1'b1, -1);

    for (int f = 0; f < 20; f++) begin
      rr = 1'($urandom_range(0, 1));
      nn = $urandom_range(0, 9);
      av = {};
      for (int i = 0; i < nn; i++) av.push_back($urandom_range(0, 6 * i + 6));
      run_frame(rr, nn, av, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
